// File: rtl/debounce_pulse_gen.sv
// Pushbutton debouncer that emits one registered pulse per accepted press,
// with a press counter and a synchronized switch bit held steady around each pulse.
module debounce_pulse_gen #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 16
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       btn_raw,
   input  logic       sw_raw,
   output logic       clk_pulse,
   output logic       inp_1,
   output logic       btn_stable,
   output logic [7:0] press_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HELD = 2'd2,
      REL  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic             btn_s1, btn_s2;
   logic             sw_s1, sw_s2;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             pulse_nxt, inp_nxt, stable_nxt;
   logic [7:0]       count_nxt;

   // State register, synchronizers and registered outputs.
   always_ff @(posedge clk) begin
      if (clear) begin
         btn_s1      <= 1'b0;
         btn_s2      <= 1'b0;
         sw_s1       <= 1'b0;
         sw_s2       <= 1'b0;
         state       <= IDLE;
         cnt         <= '0;
         clk_pulse   <= 1'b0;
         inp_1       <= 1'b0;
         btn_stable  <= 1'b0;
         press_count <= 8'd0;
      end else begin
         btn_s1      <= btn_raw;
         btn_s2      <= btn_s1;
         sw_s1       <= sw_raw;
         sw_s2       <= sw_s1;
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         clk_pulse   <= pulse_nxt;
         inp_1       <= inp_nxt;
         btn_stable  <= stable_nxt;
         press_count <= count_nxt;
      end
   end

   // Next-state logic; cnt is only live in ARM and REL.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         IDLE: if (btn_s2) state_nxt = ARM;
         ARM: begin
            if (!btn_s2)              state_nxt = IDLE;
            else if (cnt == CNT_MAX)  state_nxt = HELD;
            else                      cnt_nxt   = cnt + CNT_W'(1);
         end
         HELD: if (!btn_s2) state_nxt = REL;
         REL: begin
            if (btn_s2)               state_nxt = HELD;
            else if (cnt == CNT_MAX)  state_nxt = IDLE;
            else                      cnt_nxt   = cnt + CNT_W'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: pulse only on the ARM->HELD edge, switch sampled only while idle.
   always_comb begin
      pulse_nxt  = (state == ARM) && btn_s2 && (cnt == CNT_MAX);
      stable_nxt = (state_nxt == HELD) || (state_nxt == REL);
      inp_nxt    = (state == IDLE) ? sw_s2 : inp_1;
      count_nxt  = pulse_nxt ? press_count + 8'd1 : press_count;
      if ((state != IDLE) && (state != ARM) && (state != HELD) && (state != REL)) begin
         pulse_nxt  = 1'b0;
         stable_nxt = 1'b0;
         inp_nxt    = 1'b0;
         count_nxt  = 8'd0;
      end
   end

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Directed bench for debounce_pulse_gen: a per-cycle vector table plus a
// press-counter wrap sequence.
module tb_debounce_pulse_gen;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic       btn_raw = 1'b0;
   logic       sw_raw = 1'b0;
   logic       clk_pulse, inp_1, btn_stable;
   logic [7:0] press_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       clr;
      logic       btn;
      logic       sw;
      logic       pulse;
      logic       stable;
      logic       inp;
      logic [7:0] count;
   } vec_t;

   vec_t vecs[$];

   debounce_pulse_gen #(.DB_CYCLES(4), .CNT_W(16)) dut (
      .clk(clk),
      .clear(clear),
      .btn_raw(btn_raw),
      .sw_raw(sw_raw),
      .clk_pulse(clk_pulse),
      .inp_1(inp_1),
      .btn_stable(btn_stable),
      .press_count(press_count)
   );

   always #5 clk = ~clk;

   task automatic add(input int n, input logic clr, input logic btn, input logic sw,
                      input logic p, input logic st, input logic i, input logic [7:0] c);
      vec_t v;
      v.clr = clr; v.btn = btn; v.sw = sw;
      v.pulse = p; v.stable = st; v.inp = i; v.count = c;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic step(input logic clr, input logic btn, input logic sw);
      @(negedge clk);
      clear   = clr;
      btn_raw = btn;
      sw_raw  = sw;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int pulses;
      //    n  clr btn sw  pulse stable inp count
      add(1, 1, 0, 0, 0, 0, 0, 8'd0);   // reset
      add(6, 0, 1, 0, 0, 0, 0, 8'd0);   // clean press: sync + ARM counting
      add(1, 0, 1, 0, 1, 1, 0, 8'd1);   // pulse after edge 6
      add(2, 0, 1, 1, 0, 1, 0, 8'd1);   // switch flips while held
      add(6, 0, 0, 1, 0, 1, 0, 8'd1);   // release pending
      add(1, 0, 0, 1, 0, 0, 0, 8'd1);   // back to IDLE
      add(1, 0, 0, 1, 0, 0, 1, 8'd1);   // switch loaded in IDLE
      add(6, 0, 1, 1, 0, 0, 1, 8'd1);   // second press
      add(1, 0, 1, 1, 1, 1, 1, 8'd2);
      add(1, 0, 1, 1, 0, 1, 1, 8'd2);
      add(2, 0, 0, 1, 0, 1, 1, 8'd2);   // short release bounce
      add(4, 0, 1, 1, 0, 1, 1, 8'd2);   // REL->HELD, no pulse
      add(6, 0, 0, 1, 0, 1, 1, 8'd2);   // real release
      add(1, 0, 0, 1, 0, 0, 1, 8'd2);
      add(1, 0, 1, 1, 0, 0, 1, 8'd2);   // press bounce 1,0,1,0
      add(1, 0, 0, 1, 0, 0, 1, 8'd2);
      add(1, 0, 1, 1, 0, 0, 1, 8'd2);
      add(1, 0, 0, 1, 0, 0, 1, 8'd2);
      add(6, 0, 1, 1, 0, 0, 1, 8'd2);   // final rise then hold
      add(1, 0, 1, 1, 1, 1, 1, 8'd3);   // pulse 6 after final rise
      add(6, 0, 0, 1, 0, 1, 1, 8'd3);
      add(1, 0, 0, 1, 0, 0, 1, 8'd3);
      add(5, 0, 1, 1, 0, 0, 1, 8'd3);   // ARM reaches cnt=2
      add(1, 1, 1, 1, 0, 0, 0, 8'd0);   // clear mid-ARM
      add(2, 0, 1, 1, 0, 0, 0, 8'd0);   // synchronizer refill
      add(4, 0, 1, 1, 0, 0, 1, 8'd0);
      add(1, 0, 1, 1, 1, 1, 1, 8'd1);   // pulse 6 after clear drops
      add(6, 0, 0, 1, 0, 1, 1, 8'd1);
      add(1, 0, 0, 1, 0, 0, 1, 8'd1);
      add(6, 0, 1, 1, 0, 0, 1, 8'd1);   // press up to cnt=3
      add(1, 1, 1, 1, 0, 0, 0, 8'd0);   // clear on ARM->HELD edge suppresses pulse
      add(1, 0, 0, 0, 0, 0, 0, 8'd0);

      for (int r = 0; r < vecs.size(); r++) begin
         step(vecs[r].clr, vecs[r].btn, vecs[r].sw);
         check($sformatf("vec%0d", r),
               {20'd0, clk_pulse, btn_stable, inp_1, 1'b0, press_count},
               {20'd0, vecs[r].pulse, vecs[r].stable, vecs[r].inp, 1'b0, vecs[r].count});
      end

      // Counter wrap: 256 clean presses from a cleared state.
      step(1, 0, 0);
      check("wrap_reset", {24'd0, press_count}, 32'd0);
      pulses = 0;
      for (int k = 1; k <= 256; k++) begin
         for (int c = 0; c < 8; c++) begin
            step(0, 1, 0);
            if (clk_pulse === 1'b1) pulses++;
         end
         for (int c = 0; c < 8; c++) begin
            step(0, 0, 0);
            if (clk_pulse === 1'b1) pulses++;
         end
         if (k == 255) check("wrap_255", {24'd0, press_count}, 32'd255);
         if (k == 256) check("wrap_0", {24'd0, press_count}, 32'd0);
         if (k % 32 == 0) check($sformatf("wrap_cnt%0d", k), {24'd0, press_count}, k & 255);
      end
      check("wrap_pulses", pulses, 32'd256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/debounce_pulse_gen.md
DEBOUNCE_PULSE_GEN -- requirements
Module: debounce_pulse_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4, number of consecutive stable clk cycles required to accept a button level change (legal range 2..65535).
REQ-002 Parameter CNT_W, default 16, width of the debounce counter.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 clear  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 btn_raw  input  1  asynchronous mechanical pushbutton level; 1 = pressed.
REQ-006 sw_raw  input  1  asynchronous slide-switch level; the serial data bit for the downstream sequence detector.
REQ-007 clk_pulse  output  1  registered single-cycle pulse, one per accepted button press; drives the sequence detector's clock input.
REQ-008 inp_1  output  1  registered, synchronized switch value presented to the sequence detector.
REQ-009 btn_stable  output  1  registered debounced button level.
REQ-010 press_count  output  8  registered count of accepted presses, for display.

Function
REQ-011 btn_raw and sw_raw SHALL each pass through a 2-flop synchronizer (s1, s2) before any other use; no other logic SHALL read the raw inputs.
REQ-012 The debounce FSM SHALL have four states:
- IDLE: stable released.
- ARM: candidate press, counting.
- HELD: stable pressed.
- REL: candidate release, counting.
REQ-013 IDLE: if btn s2 = 1, the FSM SHALL go to ARM with cnt = 0; otherwise it SHALL stay in IDLE.
REQ-014 ARM, btn s2 = 0: the FSM SHALL return to IDLE with cnt = 0 (glitch rejected, no pulse).
REQ-015 ARM, btn s2 = 1: if cnt = DB_CYCLES-1 the FSM SHALL go to HELD; otherwise cnt SHALL increment.
REQ-016 HELD: if btn s2 = 0, the FSM SHALL go to REL with cnt = 0; otherwise it SHALL stay in HELD.
REQ-017 REL, btn s2 = 1: the FSM SHALL return to HELD with cnt = 0, with no new pulse.
REQ-018 REL, btn s2 = 0: if cnt = DB_CYCLES-1 the FSM SHALL go to IDLE; otherwise cnt SHALL increment.
REQ-019 clk_pulse SHALL be 1 for exactly one clk cycle: the first cycle in HELD after an ARM->HELD transition; it SHALL be 0 at all other times, including on REL->HELD.
REQ-020 Latency: with btn_raw held at 1 from clk edge 0, clk_pulse SHALL be high in the cycle after edge DB_CYCLES+2 (edge 6 for the default).
REQ-021 btn_stable SHALL be 1 in HELD and REL, and 0 in IDLE and ARM.
REQ-022 inp_1 SHALL load sw s2 only on cycles where the state is IDLE; it SHALL hold in ARM, HELD and REL, so that it is stable for at least DB_CYCLES cycles before and after each clk_pulse rising edge.
REQ-023 press_count SHALL increment by 1 in the same cycle clk_pulse is asserted, and SHALL wrap from 255 to 0.
REQ-024 States outside the four encoded states SHALL recover to IDLE on the next edge with all outputs 0.
REQ-025 cnt SHALL never exceed DB_CYCLES-1.

Reset
REQ-026 On clear = 1 at a clk edge, the following SHALL all be 0 after that edge regardless of current state:
- state = IDLE
- cnt
- synchronizer flops
- clk_pulse, inp_1, btn_stable, press_count
REQ-027 A clear asserted in the same cycle as an ARM->HELD transition SHALL suppress the pulse and leave press_count unchanged.
REQ-028 No output SHALL change until clear deasserts.

Verification
REQ-029 Clean press, DB_CYCLES=4: clear, then btn_raw=1 held 20 cycles -> exactly one clk_pulse, high after edge 6; btn_stable=1; press_count=1.
REQ-030 Bounce: btn_raw toggles 1,0,1,0 on consecutive cycles, then holds 1 -> no pulse during toggling; one pulse 6 cycles after the final rise; press_count=1.
REQ-031 Release bounce: from HELD, btn_raw 0 for 2 cycles, then 1 -> state returns to HELD, no second pulse; btn_stable stays 1.
REQ-032 Switch gating: sw_raw changes 0->1 while HELD -> inp_1 stays 0 until release is accepted (IDLE), then becomes 1 within 3 cycles.
REQ-033 Wrap: 256 clean presses -> press_count reads 255, then 0; exactly 256 pulses counted.
REQ-034 Mid-operation reset: clear asserted during ARM at cnt=2 -> next cycle all outputs 0, state IDLE; btn_raw still high -> new pulse 6 cycles after clear deasserts (synchronizer refill).
